// File: rtl/sound_pkg.sv
// Shared types and helpers for the multi-channel tone synthesiser.
package sound_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } ch_state_t;

  typedef enum logic {
    MIX_SUM  = 1'b0,
    MIX_PRIO = 1'b1
  } mix_mode_t;

  localparam int unsigned SAT_W = 32;

  // Clamp an unsigned sum to the largest out_w-bit code.
  function automatic logic [SAT_W-1:0] sat_u(input logic [SAT_W-1:0] sum,
                                             input int unsigned      out_w);
    logic [SAT_W-1:0] max_v;
    max_v = (SAT_W'(1) << out_w) - SAT_W'(1);
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave voice: IDLE/PLAY FSM with duration and half-period counters.
module tone_channel
  import sound_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DUR_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [DIV_W-1:0] period,
  input  logic [DUR_W-1:0] duration,
  output logic             busy,
  output logic             level
);

  ch_state_t        state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DIV_W-1:0] ph_q, ph_d;
  logic             level_q, level_d;
  logic             start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      ph_q    <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      ph_q    <= ph_d;
      level_q <= level_d;
    end
  end

  // A valid trigger always reloads, even on the expiry cycle.
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    ph_d    = ph_q;
    level_d = level_q;
    start   = trig && (duration != '0);
    if (start) begin
      state_d = PLAY;
      dur_d   = duration;
      ph_d    = '0;
      level_d = (period != '0);
    end else if (state_q == PLAY) begin
      dur_d = dur_q - DUR_W'(1);
      if (dur_q == DUR_W'(1)) begin
        state_d = IDLE;
        level_d = 1'b0;
        ph_d    = '0;
      end else if (period == '0) begin
        level_d = 1'b0;
        ph_d    = '0;
      end else if (ph_q >= period - DIV_W'(1)) begin
        // >= so a period shortened mid-play wraps at once instead of overflowing
        ph_d    = '0;
        level_d = ~level_q;
      end else begin
        ph_d = ph_q + DIV_W'(1);
      end
    end
  end

  assign busy  = (state_q == PLAY);
  assign level = level_q;

endmodule

// File: rtl/sound_synth.sv
// N-channel tone generator with saturating or priority mixer and mute toggle.
module sound_synth
  import sound_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DAC_W = 8,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DUR_W = 24,
  parameter int unsigned MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button_i,
  input  logic [N_CH-1:0]       trig_i,
  input  logic [N_CH*DIV_W-1:0] period_i,
  input  logic [N_CH*DUR_W-1:0] duration_i,
  input  logic [N_CH*DAC_W-1:0] volume_i,
  output logic [N_CH-1:0]       busy_o,
  output logic                  muted_o,
  output logic [DAC_W-1:0]      soundOut
);

  localparam int unsigned SUM_W = DAC_W + $clog2(N_CH) + 1;
  localparam mix_mode_t   MIX   = (MODE == 0) ? MIX_SUM : MIX_PRIO;

  logic [N_CH-1:0]  level;
  logic             button_q;
  logic [SUM_W-1:0] sum;
  logic [DAC_W-1:0] prio;
  logic             found;
  logic [DAC_W-1:0] sound_d;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tone_channel #(
      .DIV_W(DIV_W),
      .DUR_W(DUR_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .trig    (trig_i[c]),
      .period  (period_i[c*DIV_W +: DIV_W]),
      .duration(duration_i[c*DUR_W +: DUR_W]),
      .busy    (busy_o[c]),
      .level   (level[c])
    );
  end

  // Mixer: saturating sum, or lowest-index busy channel gated by its level.
  always_comb begin
    sum   = '0;
    prio  = '0;
    found = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (level[c]) sum = sum + SUM_W'(volume_i[c*DAC_W +: DAC_W]);
      if (!found && busy_o[c]) begin
        found = 1'b1;
        if (level[c]) prio = volume_i[c*DAC_W +: DAC_W];
      end
    end
    if (muted_o)             sound_d = '0;
    else if (MIX == MIX_SUM) sound_d = DAC_W'(sat_u(SAT_W'(sum), DAC_W));
    else                     sound_d = prio;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      button_q <= 1'b0;
      muted_o  <= 1'b0;
      soundOut <= '0;
    end else begin
      button_q <= button_i;
      if (button_i && !button_q) muted_o <= ~muted_o;
      soundOut <= sound_d;
    end
  end

endmodule

// File: doc/sound_synth.md
# sound_synth

Parametrised multi-channel successor to the single-voice sound generator. It holds N_CH independent tone channels, each started by a one-cycle event pulse such as a good collision, bad collision or direction change. Each channel plays a square wave of programmable period, duration and volume. A registered mixer drives the DAC code `soundOut`, either as a saturating sum of all channels or as a strict-priority selection. A button toggles global mute.

## Interface
Parameters:
- N_CH, 4, number of tone channels (1..8)
- DAC_W, 8, DAC code width
- DIV_W, 16, half-period counter width
- DUR_W, 24, duration counter width
- MODE, 0, 0 = saturating mix, 1 = priority (lowest active index wins)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- button_i  in  1  mute toggle, synchronous level
- trig_i  in  N_CH  per-channel start pulse
- period_i  in  N_CH×DIV_W  half-period in clocks; 0 = silent
- duration_i  in  N_CH×DUR_W  play length in clocks; 0 = ignore trigger
- volume_i  in  N_CH×DAC_W  amplitude while the wave is high
- busy_o  out  N_CH  channel playing
- muted_o  out  1  mute state
- soundOut  out  DAC_W  registered DAC code

## Operation
- Channel FSM states:
  - IDLE -> PLAY on trig_i[c] when duration_i[c] != 0.
  - PLAY -> IDLE when the duration counter expires.
- Trigger load, at edge k: dur_cnt = duration_i, ph_cnt = 0, level = 1, busy_o = 1.
- Each PLAY cycle:
  - dur_cnt decrements. At dur_cnt == 1 the next state is IDLE and level = 0.
  - ph_cnt increments. At ph_cnt == period_i-1, ph_cnt wraps to 0 and level toggles. Output frequency = clk/(2·period_i).
- period_i == 0: the channel is busy for its full duration, but level is held 0.
- Retrigger while in PLAY: full reload as above.
- Trigger in the same cycle as expiry: the trigger wins and the channel stays in PLAY.
- Config inputs are sampled every cycle. A change mid-play takes effect at the next phase wrap or compare.
- Mix, MODE 0:
  - Sum volume_i[c] over channels with level = 1.
  - Sum width is DAC_W+$clog2(N_CH)+1.
  - Saturate to 2^DAC_W−1.
- Mix, MODE 1: output volume_i of the lowest-index busy channel if its level = 1, else 0. Higher-index channels are ignored even while the selected channel's level is low.
- Mute:
  - A rising edge of button_i, detected against a registered copy, toggles muted_o.
  - While muted_o = 1, soundOut = 0 and the channels keep running.

## Timing
- Reset values (asserted asynchronously): soundOut = 0, busy_o = 0, muted_o = 0, all counters 0, all channels IDLE.
- Reset mid-play aborts immediately. No tone resumes after release.
- Trigger sampled at edge k:
  - busy_o = 1 after edge k.
  - soundOut reflects the channel from edge k+1, a 1-cycle mixer register.
- Expiry: busy_o falls at the edge where dur_cnt goes 1 -> 0. soundOut returns to 0 one cycle later.
- Mute:
  - button_i rises before edge m: muted_o = 1 after edge m.
  - soundOut = 0 after edge m+1.
  - Holding the button produces no further toggles.
- A PLAY of duration D lasts exactly D cycles of busy_o.

## Structure
- Package `sound_pkg`:
  - `ch_state_t` enum {IDLE, PLAY}
  - `mix_mode_t` enum {MIX_SUM, MIX_PRIO}
  - saturation helper function
- Sub-module `tone_channel`: one FSM plus phase and duration counters, outputs busy and level. It is instantiated N_CH times in a generate loop.
- Top level (`sound_synth`): button edge detect, mute flop, mixer, output register.

## Test plan
- Reset: play channel 0, then drive rst = 0 mid-tone -> soundOut = 0x00, busy_o = 0, muted_o = 0 within the same cycle. Nothing plays after release.
- Single tone: trig_i[0] pulse with period 4, duration 20, volume 0x40 -> busy_o[0] high for exactly 20 cycles. soundOut follows the pattern 0x40×4, 0x00×4, repeating, delayed by 1 cycle, then 0x00.
- Saturation (MODE 0): all 4 channels triggered together with volume 0x60 and period 8 -> soundOut = 0xFF while high (raw sum 0x180).
- Priority (MODE 1): channels 1 and 2 busy with volumes 0x30 and 0x70 -> soundOut alternates between 0x30 and 0x00 only. When channel 1 expires, the output switches to channel 2's 0x70 pattern.
- Mute: button pulse during a tone -> muted_o = 1, soundOut = 0 while busy_o stays 1. A second pulse -> the tone resumes. A held button -> exactly one toggle.
- Boundaries:
  - Retrigger on the final duration cycle -> busy_o never drops and plays a full new duration.
  - period 0 -> busy but soundOut = 0.
  - duration 0 -> busy_o stays 0.
